// File: rtl/fibonacci_generator.sv
// rtl/fibonacci_generator.sv - iterative F(n) producer with saturating overflow and done strobe
// Optional FIB_STREAM_EN adds term_valid_o/term_o streaming F(0)..F(n-1) during iteration.
module fibonacci_generator #(
  parameter int N_W   = 6,
  parameter int MAX_N = 47
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           go_i,
  input  logic [N_W-1:0] idx_i,
  output logic [31:0]    fib_o,
  output logic           done_o,
  output logic           busy_o,
  output logic           overflow_o,
`ifdef FIB_STREAM_EN
  output logic           term_valid_o,
  output logic [31:0]    term_o,
`endif
  output logic [3:0]     stuckState
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LOAD = 4'd1,
    ITER = 4'd2,
    DONE = 4'd3
  } stateT;

  localparam logic [N_W-1:0] MAX_IDX = N_W'(MAX_N);

  stateT          state;
  logic [31:0]    fibA;
  logic [31:0]    fibB;
  logic [N_W-1:0] cnt;
  logic [N_W-1:0] nQ;

  assign stuckState = state;

  // done_o trails the DONE state by one cycle, so it is seen while the FSM is back in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fibA       <= 32'd0;
      fibB       <= 32'd1;
      cnt        <= '0;
      nQ         <= '0;
      fib_o      <= 32'd0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
`ifdef FIB_STREAM_EN
      term_valid_o <= 1'b0;
      term_o       <= 32'd0;
`endif
    end else begin
      done_o <= (state == DONE);
`ifdef FIB_STREAM_EN
      term_valid_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (go_i) begin
            nQ     <= idx_i;
            state  <= LOAD;
            busy_o <= 1'b1;
          end
        end
        LOAD: begin
          fibA <= 32'd0;
          fibB <= 32'd1;
          cnt  <= '0;
          // overflow_o is only touched on entry to DONE so it stays paired with fib_o
          if (nQ > MAX_IDX) begin
            overflow_o <= 1'b1;
            fib_o      <= 32'hFFFF_FFFF;
            state      <= DONE;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          if (cnt == nQ) begin
            fib_o      <= fibA;
            overflow_o <= 1'b0;
            state      <= DONE;
          end else begin
            fibA <= fibB;
            fibB <= fibA + fibB;
            cnt  <= cnt + 1'b1;
`ifdef FIB_STREAM_EN
            term_valid_o <= 1'b1;
            term_o       <= fibA;
`endif
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_generator.sv
// tb/tb_fibonacci_generator.sv - directed table-driven bench for fibonacci_generator
module tb_fibonacci_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        go_i;
  logic [5:0]  idx_i;
  logic [31:0] fib_o;
  logic        done_o;
  logic        busy_o;
  logic        overflow_o;
  logic [3:0]  stuckState;
`ifdef FIB_STREAM_EN
  logic        term_valid_o;
  logic [31:0] term_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fibonacci_generator #(.N_W(6), .MAX_N(47)) dut (
    .clk(clk),
    .reset(reset),
    .go_i(go_i),
    .idx_i(idx_i),
    .fib_o(fib_o),
    .done_o(done_o),
    .busy_o(busy_o),
    .overflow_o(overflow_o),
`ifdef FIB_STREAM_EN
    .term_valid_o(term_valid_o),
    .term_o(term_o),
`endif
    .stuckState(stuckState)
  );

  typedef struct {
    int          n;
    logic [31:0] expFib;
    logic        expOvf;
    int          expLat;
  } vecT;

  vecT vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench at the negedge just after the edge that sampled go_i.
  task automatic issue(input int n);
    @(negedge clk);
    go_i  = 1'b1;
    idx_i = 6'(n);
    @(negedge clk);
    go_i  = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busyCnt);
    lat = 0;
    busyCnt = 0;
    while (!done_o && lat < 300) begin
      if (busy_o) busyCnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, busyCnt, cntDone, t, last;
    vecs[0] = '{0, 32'd0, 1'b0, 3};
    vecs[1] = '{1, 32'd1, 1'b0, 4};
    vecs[2] = '{2, 32'd1, 1'b0, 5};
    vecs[3] = '{3, 32'd2, 1'b0, 6};
    vecs[4] = '{10, 32'd55, 1'b0, 13};
    vecs[5] = '{20, 32'd6765, 1'b0, 23};
    vecs[6] = '{30, 32'd832040, 1'b0, 33};
    vecs[7] = '{47, 32'hB11924E1, 1'b0, 50};
    vecs[8] = '{48, 32'hFFFFFFFF, 1'b1, 2};
    vecs[9] = '{63, 32'hFFFFFFFF, 1'b1, 2};

    reset = 1'b1;
    go_i  = 1'b0;
    idx_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_fib", fib_o, 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_state", 32'(stuckState), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].n);
      waitDone(lat, busyCnt);
      chk($sformatf("lat_n%0d", vecs[i].n), 32'(lat), 32'(vecs[i].expLat));
      chk($sformatf("fib_n%0d", vecs[i].n), fib_o, vecs[i].expFib);
      chk($sformatf("ovf_n%0d", vecs[i].n), 32'(overflow_o), 32'(vecs[i].expOvf));
      if (vecs[i].n == 10) chk("busy_n10", 32'(busyCnt), 32'd13);
      @(negedge clk);
      chk($sformatf("strobe_n%0d", vecs[i].n), 32'(done_o), 32'd0);
      chk($sformatf("hold_n%0d", vecs[i].n), fib_o, vecs[i].expFib);
    end

    // asynchronous reset in the middle of an n=20 iteration
    issue(20);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", 32'(stuckState), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_fib", fib_o, 32'd0);
    chk("arst_ovf", 32'(overflow_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cntDone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_o) cntDone++;
    end
    chk("arst_nodone", 32'(cntDone), 32'd0);
    issue(3);
    waitDone(lat, busyCnt);
    chk("arst_next_fib", fib_o, 32'd2);
    chk("arst_next_lat", 32'(lat), 32'd6);

    // go while busy is ignored
    issue(30);
    repeat (5) @(negedge clk);
    go_i  = 1'b1;
    idx_i = 6'd5;
    @(negedge clk);
    go_i  = 1'b0;
    waitDone(lat, busyCnt);
    chk("ign_lat", 32'(lat + 6), 32'd33);
    chk("ign_fib", fib_o, 32'd832040);
    cntDone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) cntDone++;
    end
    chk("ign_nodone", 32'(cntDone), 32'd0);

    // go held high: back-to-back n=6 requests
    @(negedge clk);
    go_i  = 1'b1;
    idx_i = 6'd6;
    @(negedge clk);
    t = 0;
    last = 0;
    cntDone = 0;
    while (cntDone < 3 && t < 100) begin
      if (done_o) begin
        chk("b2b_fib", fib_o, 32'd8);
        if (cntDone == 0) chk("b2b_first", 32'(t), 32'd9);
        else chk("b2b_gap", 32'(t - last), 32'd10);
        last = t;
        cntDone++;
        if (cntDone == 3) go_i = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    go_i = 1'b0;
    chk("b2b_count", 32'(cntDone), 32'd3);
    repeat (3) @(negedge clk);

`ifdef FIB_STREAM_EN
    begin
      logic [31:0] expTerms[6];
      int nt;
      expTerms = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5};
      nt = 0;
      issue(6);
      t = 0;
      while (!done_o && t < 100) begin
        if (term_valid_o) begin
          if (nt < 6) chk($sformatf("term%0d", nt), term_o, expTerms[nt]);
          nt++;
        end
        @(negedge clk);
        t++;
      end
      chk("term_count", 32'(nt), 32'd6);
      chk("term_fib", fib_o, 32'd8);
      nt = 0;
      issue(50);
      t = 0;
      while (!done_o && t < 100) begin
        if (term_valid_o) nt++;
        @(negedge clk);
        t++;
      end
      chk("term_ovf_none", 32'(nt), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
